debug_uart_rx: RTL

- Debug-port UART receiver sitting directly downstream of the debug auto-baud detector.
- Consumes the detector's divisor write (div_wr/div) and selected-input code (rx_sel).
- Muxes and synchronizes the chosen RX pin, then deserializes 8N1 frames with 16x oversampling.
- Hands received bytes to the debug command parser over a valid/ready interface, with framing-error and overrun status.

---
 rtl/debug_uart_rx_pkg.sv | 29 ++
 rtl/debug_uart_rx_baud_gen.sv | 47 ++++
 rtl/debug_uart_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_rx_pkg.sv
// Shared types and constants for the debug-port UART receiver.
// Included by debug_baud_gen and debug_uart_rx.
package debug_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVS       = 16;
  localparam int MID_TICK  = 8;
  localparam int DATA_BITS = 8;

  localparam logic [1:0] RX_SEL_NONE = 2'd0;
  localparam logic [1:0] RX_SEL_RX1  = 2'd1;
  localparam logic [1:0] RX_SEL_RX2  = 2'd2;
  localparam logic [1:0] RX_SEL_RX3  = 2'd3;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/debug_uart_rx_baud_gen.sv
// 16x oversampling tick generator: one tick every 2*div_q clocks.
// restart re-phases the count to the detected start edge.
module debug_baud_gen
  import debug_uart_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_q,
  input  logic             restart,
  input  logic             enable,
  output logic             tick
);

  localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

  logic [DIV_W:0] cnt_q;
  logic [DIV_W:0] cnt_d;
  logic [DIV_W:0] cnt_top;

  assign cnt_top = {div_q, 1'b0} - ONE;

  assign tick = enable && !restart &&
                (div_q != '0) &&
                (cnt_q == cnt_top);

  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_uart_rx.sv
// Debug-port 8N1 UART receiver fed by the auto-baud detector.
// DEBUG_UART_RX_MAJORITY_EN: 3-sample majority bit decisions.
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int             DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       rx_sel,
  input  logic             rx1,
  input  logic             rx2,
  input  logic             rx3,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam logic [3:0] MID_LAST = 4'(MID_TICK - 1);
  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e state_q;
  rx_state_e state_d;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             line_q;
  logic [3:0]       tick_cnt_q;
  logic [3:0]       tick_cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             deliver_q;
  logic             deliver_d;
  logic             frame_err_q;
  logic             frame_err_d;
  logic [7:0]       rx_data_q;
  logic [7:0]       rx_data_d;
  logic             rx_valid_q;
  logic             rx_valid_d;
  logic             overrun_q;
  logic             overrun_d;
`ifdef DEBUG_UART_RX_MAJORITY_EN
  logic [1:0]       hist_q;
  logic [1:0]       hist_d;
`endif

  logic pin_mux;
  logic fall;
  logic bit_val;
  logic tick;
  logic restart;
  logic hs;

  always_comb begin
    pin_mux = 1'b1;
    unique case (1'b1)
      (rx_sel == RX_SEL_RX1): pin_mux = rx1;
      (rx_sel == RX_SEL_RX2): pin_mux = rx2;
      (rx_sel == RX_SEL_RX3): pin_mux = rx3;
      default:                pin_mux = 1'b1;
    endcase
  end

  assign fall = line_q & ~sync2_q;

`ifdef DEBUG_UART_RX_MAJORITY_EN
  // history holds the two previous ticks' samples
  assign bit_val = maj3(hist_q[1], hist_q[0], sync2_q);
`else
  assign bit_val = sync2_q;
`endif

  debug_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .div_q   (div_q),
    .restart (restart),
    .enable  (state_q != IDLE),
    .tick    (tick)
  );

  assign div_d = div_wr ? div : div_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;
`ifdef DEBUG_UART_RX_MAJORITY_EN
    hist_d      = hist_q;
    if (tick && state_q != IDLE) begin
      hist_d = {hist_q[0], sync2_q};
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (fall && div_q != '0) begin
          state_d    = START;
          restart    = 1'b1;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == MID_LAST) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = bit_val ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == OVS_LAST) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = bit_val;
            if (bit_idx_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == OVS_LAST) begin
            tick_cnt_d  = '0;
            state_d     = IDLE;
            deliver_d   = bit_val;
            frame_err_d = ~bit_val;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a new divisor invalidates whatever was being sampled
    if (div_wr) begin
      state_d     = IDLE;
      restart     = 1'b0;
      deliver_d   = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign hs = rx_valid_q & rx_ready;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (hs) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= RST_DIV;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DEBUG_UART_RX_MAJORITY_EN
      hist_q      <= 2'b11;
`endif
    end else begin
      div_q       <= div_d;
      sync1_q     <= pin_mux;
      sync2_q     <= sync1_q;
      line_q      <= sync2_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
`ifdef DEBUG_UART_RX_MAJORITY_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
